// File: rtl/hazard_unit.sv
// hazard_unit: stall, flush and forward control for the five-stage MIPS core.
// Define HAZARD_FWD_EN for forwarding; otherwise it is a full RAW interlock.
module hazard_unit #(
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic       branchD,
  input  logic       jumpD,
  input  logic       pcsrcD,
  input  logic [4:0] writeregE,
  input  logic       regwriteE,
  input  logic       memtoregE,
  input  logic       mdstartE,
  output logic       stallF,
  output logic       stallD,
  output logic       flushD,
  output logic       flushE,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       mdbusy
);

  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } md_state_e;

  localparam logic [5:0] CNT_INIT = 6'(MD_CYCLES - 1);

  md_state_e  state_q, state_d;
  logic [5:0] cnt_q, cnt_d;

  logic [4:0] rsE_q, rtE_q;
  logic [4:0] writeregM_q, writeregW_q;
  logic       regwriteM_q, regwriteW_q;
  logic       memtoregM_q;
  logic       stall;

  function automatic logic hit(
    input logic [4:0] a,
    input logic [4:0] b
  );
    return (a != 5'd0) && (a == b);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsE_q       <= '0;
      rtE_q       <= '0;
      writeregM_q <= '0;
      writeregW_q <= '0;
      regwriteM_q <= 1'b0;
      regwriteW_q <= 1'b0;
      memtoregM_q <= 1'b0;
    end else begin
      rsE_q       <= stall ? 5'd0 : rsD;
      rtE_q       <= stall ? 5'd0 : rtD;
      writeregM_q <= writeregE;
      writeregW_q <= writeregM_q;
      regwriteM_q <= regwriteE;
      regwriteW_q <= regwriteM_q;
      memtoregM_q <= memtoregE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // mdstartE cannot legally arrive while busy, so BUSY ignores it
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MD_IDLE: begin
        if (mdstartE) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      MD_BUSY: begin
        if (cnt_q != 6'd0) begin
          cnt_d = cnt_q - 6'd1;
        end else begin
          state_d = MD_IDLE;
        end
      end
    endcase
  end

  assign mdbusy = (state_q == MD_BUSY);

`ifdef HAZARD_FWD_EN
  logic lwstall;
  logic branchstall;

  assign lwstall = memtoregE
                 & (hit(rsD, writeregE) | hit(rtD, writeregE));

  assign branchstall = branchD
    & ((regwriteE
        & (hit(rsD, writeregE) | hit(rtD, writeregE)))
     | (memtoregM_q
        & (hit(rsD, writeregM_q) | hit(rtD, writeregM_q))));

  assign stall = lwstall | branchstall | mdbusy;

  assign forwardAD = regwriteM_q & hit(rsD, writeregM_q);
  assign forwardBD = regwriteM_q & hit(rtD, writeregM_q);

  always_comb begin
    forwardAE = 2'b00;
    if (regwriteM_q && hit(rsE_q, writeregM_q)) begin
      forwardAE = 2'b10;
    end else if (regwriteW_q && hit(rsE_q, writeregW_q)) begin
      forwardAE = 2'b01;
    end
  end

  always_comb begin
    forwardBE = 2'b00;
    if (regwriteM_q && hit(rtE_q, writeregM_q)) begin
      forwardBE = 2'b10;
    end else if (regwriteW_q && hit(rtE_q, writeregW_q)) begin
      forwardBE = 2'b01;
    end
  end
`else
  logic raw_e;
  logic raw_m;
  logic unused_fwd;

  // W is written in the first half-cycle, so only E and M interlock
  assign raw_e = regwriteE
               & (hit(rsD, writeregE) | hit(rtD, writeregE));
  assign raw_m = regwriteM_q
               & (hit(rsD, writeregM_q) | hit(rtD, writeregM_q));

  assign stall = raw_e | raw_m | mdbusy;

  assign forwardAD = 1'b0;
  assign forwardBD = 1'b0;
  assign forwardAE = 2'b00;
  assign forwardBE = 2'b00;

  assign unused_fwd = ^{branchD, memtoregE, memtoregM_q,
                        rsE_q, rtE_q, writeregW_q, regwriteW_q};
`endif

  assign stallF = stall;
  assign stallD = stall;
  assign flushE = stall;
  assign flushD = (pcsrcD | jumpD) & ~stall;

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed scenarios plus random stimulus checked every
// cycle against a pipeline-history model of the hazard rules.
module tb_hazard_unit;

  localparam int MD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rsD, rtD, writeregE;
  logic       branchD, jumpD, pcsrcD;
  logic       regwriteE, memtoregE, mdstartE;
  logic       stallF, stallD, flushD, flushE;
  logic       forwardAD, forwardBD, mdbusy;
  logic [1:0] forwardAE, forwardBE;

  int checks = 0;
  int errors = 0;

  hazard_unit #(.MD_CYCLES(MD)) dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD),
    .branchD(branchD), .jumpD(jumpD), .pcsrcD(pcsrcD),
    .writeregE(writeregE),
    .regwriteE(regwriteE), .memtoregE(memtoregE),
    .mdstartE(mdstartE),
    .stallF(stallF), .stallD(stallD),
    .flushD(flushD), .flushE(flushE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .mdbusy(mdbusy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 0) && (a == b);
  endfunction

  // model state: what instruction sits in E/M/W, and busy cycles left
  logic [4:0] m_rsE, m_rtE;
  logic [4:0] m_wr [2];
  logic       m_rw [2];
  logic       m_mtrM;
  int         busy_left;

  logic       e_stall, e_flushD, e_fAD, e_fBD, e_busy;
  logic [1:0] e_fAE, e_fBE;

  function automatic logic [1:0] fsel(input logic [4:0] r);
    if (m_rw[0] && hit(r, m_wr[0])) return 2'd2;
    if (m_rw[1] && hit(r, m_wr[1])) return 2'd1;
    return 2'd0;
  endfunction

  always_comb begin
    e_busy = (busy_left != 0);
`ifdef HAZARD_FWD_EN
    e_fAE = fsel(m_rsE);
    e_fBE = fsel(m_rtE);
    e_fAD = m_rw[0] && hit(rsD, m_wr[0]);
    e_fBD = m_rw[0] && hit(rtD, m_wr[0]);
    e_stall = (memtoregE && (hit(rsD, writeregE) || hit(rtD, writeregE)))
           || (branchD && regwriteE
               && (hit(rsD, writeregE) || hit(rtD, writeregE)))
           || (branchD && m_mtrM
               && (hit(rsD, m_wr[0]) || hit(rtD, m_wr[0])))
           || e_busy;
`else
    e_fAE = 2'd0;
    e_fBE = 2'd0;
    e_fAD = 1'b0;
    e_fBD = 1'b0;
    e_stall = (regwriteE && (hit(rsD, writeregE) || hit(rtD, writeregE)))
           || (m_rw[0] && (hit(rsD, m_wr[0]) || hit(rtD, m_wr[0])))
           || e_busy;
`endif
    e_flushD = (pcsrcD || jumpD) && !e_stall;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_rsE <= 0; m_rtE <= 0;
      m_wr[0] <= 0; m_wr[1] <= 0;
      m_rw[0] <= 0; m_rw[1] <= 0;
      m_mtrM <= 0;
      busy_left <= 0;
    end else begin
      m_rsE <= e_stall ? 5'd0 : rsD;
      m_rtE <= e_stall ? 5'd0 : rtD;
      m_wr[0] <= writeregE; m_wr[1] <= m_wr[0];
      m_rw[0] <= regwriteE; m_rw[1] <= m_rw[0];
      m_mtrM <= memtoregE;
      if (busy_left != 0) busy_left <= busy_left - 1;
      else if (mdstartE) busy_left <= MD;
    end
  end

  always @(negedge clk) begin
    chk("stallF", stallF, e_stall);
    chk("stallD", stallD, e_stall);
    chk("flushE", flushE, e_stall);
    chk("flushD", flushD, e_flushD);
    chk("forwardAD", forwardAD, e_fAD);
    chk("forwardBD", forwardBD, e_fBD);
    chk("forwardAE", forwardAE, e_fAE);
    chk("forwardBE", forwardBE, e_fBE);
    chk("mdbusy", mdbusy, e_busy);
  end

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic br, input logic jp, input logic pc,
                       input logic [4:0] wr, input logic rw,
                       input logic mtr, input logic md);
    rsD = rs; rtD = rt;
    branchD = br; jumpD = jp; pcsrcD = pc;
    writeregE = wr; regwriteE = rw; memtoregE = mtr;
    mdstartE = md;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      nxt();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    int nb;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stallD", stallD, 0);
    chk("rst_fAE", forwardAE, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    // multiply/divide busy length; second pulse during BUSY ignored
    nxt();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    nxt();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nb = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mdbusy && stallD && flushE) nb++;
      mdstartE = (i == 1);
    end
    chk("md_busy_len", nb, MD);

    // reset asserted mid-BUSY
    nxt();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    nxt();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("md_busy_on", mdbusy, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_busy", mdbusy, 0);
    chk("rst_mid_stall", stallD, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", mdbusy, 0);
    chk("post_rst_flushD", flushD, 0);

    // ALU RAW: producer of $8 in E while consumer in D
    idle(2);
    nxt();
    drive(8, 0, 0, 0, 0, 8, 1, 0, 0);
    @(negedge clk);
`ifdef HAZARD_FWD_EN
    chk("raw_a_stall", stallD, 0);
`else
    chk("raw_a_stall", stallD, 1);
`endif
    nxt();
    drive(8, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
`ifdef HAZARD_FWD_EN
    chk("raw_b_fAE", forwardAE, 2);
`else
    chk("raw_b_stall", stallD, 1);
`endif
    nxt();
    drive(8, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
`ifdef HAZARD_FWD_EN
    chk("raw_c_fAE", forwardAE, 1);
`else
    chk("raw_c_stall", stallD, 0);
`endif

    // both M and W write $9: M wins
    idle(2);
    nxt();
    drive(0, 0, 0, 0, 0, 9, 1, 0, 0);
    nxt();
    drive(9, 0, 0, 0, 0, 9, 1, 0, 0);
    nxt();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
`ifdef HAZARD_FWD_EN
    chk("mw_fAE", forwardAE, 2);
`else
    chk("mw_fAE", forwardAE, 0);
`endif
    nxt();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("zero_fAE", forwardAE, 0);

    // load-use on rt
    idle(2);
    nxt();
    drive(0, 5, 0, 0, 0, 5, 1, 1, 0);
    @(negedge clk);
    chk("lu_stallF", stallF, 1);
    chk("lu_flushE", flushE, 1);
    nxt();
    drive(0, 5, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
`ifdef HAZARD_FWD_EN
    chk("lu_b_stall", stallD, 0);
    chk("lu_b_fBE", forwardBE, 0);
`else
    chk("lu_b_stall", stallD, 1);
`endif
    nxt();
    drive(0, 5, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
`ifdef HAZARD_FWD_EN
    chk("lu_c_fBE", forwardBE, 1);
`else
    chk("lu_c_stall", stallD, 0);
`endif

    // taken branch on a load result: two bubbles
    idle(2);
    nxt();
    drive(4, 0, 1, 0, 1, 4, 1, 1, 0);
    @(negedge clk);
    chk("bl_a_stall", stallD, 1);
    chk("bl_a_flushD", flushD, 0);
    nxt();
    drive(4, 0, 1, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("bl_b_stall", stallD, 1);
    chk("bl_b_flushD", flushD, 0);
    nxt();
    drive(4, 0, 1, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("bl_c_stall", stallD, 0);
    chk("bl_c_fAD", forwardAD, 0);
    chk("bl_c_flushD", flushD, 1);

    // taken branch on an ALU result
    idle(2);
    nxt();
    drive(4, 0, 1, 0, 1, 4, 1, 0, 0);
    @(negedge clk);
    chk("ba_a_stall", stallD, 1);
    nxt();
    drive(4, 0, 1, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
`ifdef HAZARD_FWD_EN
    chk("ba_b_stall", stallD, 0);
    chk("ba_b_fAD", forwardAD, 1);
    chk("ba_b_flushD", flushD, 1);
`else
    chk("ba_b_stall", stallD, 1);
    chk("ba_b_flushD", flushD, 0);
`endif
    nxt();
    drive(4, 0, 1, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("ba_c_flushD", flushD, 1);

    // jump with no hazard
    idle(2);
    nxt();
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("jump_flushD", flushD, 1);

    // random traffic over a small register range
    for (int i = 0; i < 3000; i++) begin
      logic mtr;
      nxt();
      mtr = ($urandom_range(0, 3) == 0);
      drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            mtr | 1'($urandom_range(0, 1)), mtr,
            ($urandom_range(0, 19) == 0));
    end
    idle(MD + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
